// File: rtl/seg7_pkg.sv
// Shared seven-segment constants, conversion FSM states and the BCD digit-count helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low patterns, bit 0 = segment a, bit 6 = segment g
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Decimal digits needed for the largest width-bit value, i.e. ceil(width*log10(2))
  function automatic int unsigned bcd_digits(input int unsigned width);
    logic [63:0] v;
    int unsigned n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decode; non-decimal codes blank.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0: seg_c = SEG_DIGIT[0];
      4'd1: seg_c = SEG_DIGIT[1];
      4'd2: seg_c = SEG_DIGIT[2];
      4'd3: seg_c = SEG_DIGIT[3];
      4'd4: seg_c = SEG_DIGIT[4];
      4'd5: seg_c = SEG_DIGIT[5];
      4'd6: seg_c = SEG_DIGIT[6];
      4'd7: seg_c = SEG_DIGIT[7];
      4'd8: seg_c = SEG_DIGIT[8];
      4'd9: seg_c = SEG_DIGIT[9];
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seq_bin_to_seg_display.sv
// Iterative double-dabble binary to BCD with registered seven-segment outputs.
// Define SEG_LZ_BLANK_EN to blank leading zero digits on the display.
module seq_bin_to_seg_display
  import seg7_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      binary_in,
  output logic [7*DIGITS-1:0]   seg,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned NDIG = bcd_digits(WIDTH);
  localparam int unsigned NB   = (NDIG > DIGITS) ? NDIG : DIGITS;
  localparam int unsigned SRW  = 4*NB + WIDTH;
  localparam int unsigned CW   = $clog2(WIDTH + 1);

  state_t              state, state_nxt;
  logic [SRW-1:0]      sr, sr_nxt, sr_adj;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [4*DIGITS-1:0] bcd_res, bcd_nxt;
  logic [7*DIGITS-1:0] seg_dec, seg_nxt;
  logic                ovf_res, ovf_nxt, done_nxt;
  logic [DIGITS-1:0]   lz;

  assign in_ready = (state == IDLE);

  // After WIDTH shifts the binary field is empty and the BCD sits above it
  assign bcd_res = sr[WIDTH +: 4*DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    bcd_to_seg7 u_dec (
      .bcd   (bcd_res[4*k +: 4]),
      .seg_c (seg_dec[7*k +: 7])
    );
  end

  always_comb begin
    ovf_res = 1'b0;
    for (int k = DIGITS; k < NB; k++) begin
      ovf_res = ovf_res | (sr[WIDTH + 4*k +: 4] != 4'd0);
    end
  end

`ifdef SEG_LZ_BLANK_EN
  always_comb begin : lz_blank
    logic nz;
    nz = 1'b0;
    lz = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      nz    = nz | (bcd_res[4*k +: 4] != 4'd0);
      lz[k] = ~nz;
    end
  end
`else
  assign lz = '0;
`endif

  // Add-3 correction on every nibble that will overflow past 9 once doubled
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < NB; k++) begin
      if (sr[WIDTH + 4*k +: 4] >= 4'd5) begin
        sr_adj[WIDTH + 4*k +: 4] = sr[WIDTH + 4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      bcd_out  <= '0;
      seg      <= '1;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      cnt      <= cnt_nxt;
      bcd_out  <= bcd_nxt;
      seg      <= seg_nxt;
      overflow <= ovf_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    bcd_nxt   = bcd_out;
    seg_nxt   = seg;
    ovf_nxt   = overflow;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sr_nxt    = SRW'(binary_in);
          cnt_nxt   = CW'(WIDTH);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sr_nxt  = {sr_adj[SRW-2:0], 1'b0};
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        bcd_nxt  = bcd_res;
        ovf_nxt  = ovf_res;
        for (int k = 0; k < DIGITS; k++) begin
          seg_nxt[7*k +: 7] = ovf_res ? SEG_DASH : (lz[k] ? SEG_BLANK : seg_dec[7*k +: 7]);
        end
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_bin_to_seg_display.sv
// Table-driven scoreboard bench for seq_bin_to_seg_display (WIDTH=16, DIGITS=4).
module tb_seq_bin_to_seg_display;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [WIDTH-1:0]    binary_in = '0;
  logic [7*DIGITS-1:0] seg;
  logic [4*DIGITS-1:0] bcd_out;
  logic                overflow;
  logic                done;

  seq_bin_to_seg_display #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .binary_in (binary_in),
    .seg       (seg),
    .bcd_out   (bcd_out),
    .overflow  (overflow),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [27:0] seg;
    logic        ovf;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] val;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] model_seg(input logic [15:0] b, input logic ovf);
    logic [27:0] s;
    logic        lead;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      lead = ((b >> (4*k)) == 16'd0) && (k > 0);
`ifndef SEG_LZ_BLANK_EN
      lead = 1'b0;
`endif
      if (ovf)       s[7*k +: 7] = 7'b0111111;
      else if (lead) s[7*k +: 7] = 7'b1111111;
      else           s[7*k +: 7] = pat(b[4*k +: 4]);
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_latency", cyc, e.acc + WIDTH + 1);
        check("bcd_out", bcd_out, e.bcd);
        check("seg", seg, e.seg);
        check("overflow", overflow, e.ovf);
      end
    end
  end

  task automatic send(input logic [15:0] v, input logic [15:0] ebcd, input logic eovf);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    binary_in = v;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_ready expected=ready");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.bcd = ebcd;
    e.seg = model_seg(ebcd, eovf);
    e.ovf = eovf;
    e.acc = cyc;
    sb.push_back(e);
    in_valid  = 1'b0;
    binary_in = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  vec_t tbl[9];
  int   busy_ready;
  int   acc1;
  exp_t e;

  initial begin
    tbl[0] = '{16'd1234,  16'h1234, 1'b0};
    tbl[1] = '{16'd9999,  16'h9999, 1'b0};
    tbl[2] = '{16'd10000, 16'h0000, 1'b1};
    tbl[3] = '{16'd65535, 16'h5535, 1'b1};
    tbl[4] = '{16'd0,     16'h0000, 1'b0};
    tbl[5] = '{16'd1000,  16'h1000, 1'b0};
    tbl[6] = '{16'd999,   16'h0999, 1'b0};
    tbl[7] = '{16'd50,    16'h0050, 1'b0};
    tbl[8] = '{16'd8191,  16'h8191, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_seg", seg, 28'hFFFFFFF);
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_ovf", overflow, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", in_ready, 1'b1);

    for (int i = 0; i < 9; i++) send(tbl[i].val, tbl[i].bcd, tbl[i].ovf);
    drain();

    send(16'd1234, 16'h1234, 1'b0);
    drain();
    check("seg_1234", seg, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    send(16'd0, 16'h0000, 1'b0);
    drain();
`ifdef SEG_LZ_BLANK_EN
    check("seg_zero", seg, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
`else
    check("seg_zero", seg, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
`endif

    send(16'd65535, 16'h5535, 1'b1);
    drain();
    check("seg_dash", seg, {4{7'b0111111}});

    // Back-to-back with in_valid held high across the busy period
    @(negedge clk);
    in_valid  = 1'b1;
    binary_in = 16'd42;
    @(posedge clk);
    #1;
    e.bcd = 16'h0042; e.seg = model_seg(16'h0042, 1'b0); e.ovf = 1'b0; e.acc = cyc;
    sb.push_back(e);
    acc1 = cyc;
    binary_in  = 16'd7;
    busy_ready = 0;
    repeat (17) begin
      @(negedge clk);
      if (in_ready) busy_ready++;
    end
    check("busy_ready", busy_ready, 0);
    @(negedge clk);
    check("done_cycle_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_accept", cyc, acc1 + 18);
    e.bcd = 16'h0007; e.seg = model_seg(16'h0007, 1'b0); e.ovf = 1'b0; e.acc = cyc;
    sb.push_back(e);
    in_valid  = 1'b0;
    binary_in = 16'd999;
    drain();

    // Reset in the middle of a conversion
    send(16'd500, 16'h0500, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    check("midrst_seg", seg, 28'hFFFFFFF);
    check("midrst_bcd", bcd_out, 16'h0000);
    check("midrst_ovf", overflow, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    repeat (25) @(negedge clk);
    send(16'd321, 16'h0321, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bin_to_seg_display.md
Name: seq_bin_to_seg_display

Overview:
- Parametrised, sequential successor to the combinational binary→BCD→7-segment path.
- Converts a WIDTH-bit unsigned value to DIGITS BCD digits with an iterative double-dabble, one bit per clock, behind a valid/ready handshake.
- Drives DIGITS registered active-low seven-segment outputs, with overflow indication when the value exceeds 10^DIGITS-1.
- Sits between datapath/counter logic and the board HEX displays.

Parameters:
- WIDTH, 16, input binary width; legal range 4..32.
- DIGITS, 4, number of displayed BCD digits and seven-segment outputs; legal range 1..8.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  binary_in is valid.
- in_ready  out  1  block can accept a value; high only in IDLE.
- binary_in  in  WIDTH  unsigned value, sampled on accept.
- seg  out  7*DIGITS  active-low segments a-g; digit k at bits [7k+6:7k]; digit 0 is units.
- bcd_out  out  4*DIGITS  registered BCD result; digit k at bits [4k+3:4k].
- overflow  out  1  last result exceeded 10^DIGITS-1.
- done  out  1  one-cycle pulse; outputs were updated on this edge.

Behaviour:
- Reset (rst=0 at a rising edge):
  - Outputs: seg all 1s (blank), bcd_out=0, overflow=0, done=0.
  - State goes to IDLE, so in_ready=1 after reset.
  - Reset aborts any conversion in progress; the partial result is discarded.
- Internal width:
  - NDIG = bcd_digits(WIDTH) = ceil(WIDTH*log10(2)); for WIDTH=16, NDIG=5.
  - The shift register is 4*max(NDIG,DIGITS)+WIDTH bits wide.
  - A bit counter counts WIDTH iterations.
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - in_ready=1 (combinational from state).
  - On in_valid&&in_ready at edge E0: load {zeros, binary_in}, set the counter to WIDTH, go to SHIFT.
- SHIFT, at each edge:
  - Add 3 to every BCD nibble that is >=5, then shift the whole register left by 1, then decrement the counter.
  - The edge at which the counter reaches 0 is E_WIDTH; go to LATCH.
- LATCH, at edge E_WIDTH+1:
  - overflow is set if any nibble above digit DIGITS-1 is nonzero.
  - bcd_out takes the low DIGITS nibbles.
  - seg is decoded from bcd_out. If overflow=1, every digit shows dash (7'b0111111) instead.
  - done=1 for exactly the following cycle; go to IDLE.
- Latency: done is high in the cycle after edge E_WIDTH+1 (WIDTH+1 edges after accept). Throughput is one result per WIDTH+2 cycles.
- Back-to-back: in the done cycle the state is IDLE and in_ready=1. An accept in that cycle is legal and starts the next conversion; seg/bcd_out hold until the next LATCH.
- Holding: outputs hold their last value between conversions. in_valid is ignored outside IDLE; binary_in changes after accept have no effect.
- Decode: digits 0-9 use the standard active-low patterns (0 = 7'b1000000 … 9 = 7'b0010000). Any nibble >9 is impossible after double-dabble; it decodes to blank defensively.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined:
  - Leading-zero blanking. Digits above the most significant nonzero digit show blank (7'b1111111).
  - Digit 0 always shows its value, so 0 displays a single "0".
  - Overflow dashes override blanking.
  - bcd_out is unaffected.
- Undefined: all DIGITS digits are always shown, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK, SEG_DASH, and the SEG_DIGIT[0:9] pattern constants.
  - State enum typedef (IDLE/SHIFT/LATCH).
  - Constant function bcd_digits(width).
- Sub-module bcd_to_seg7: combinational 4-bit BCD → 7-bit active-low decode, instantiated DIGITS times via generate.

Test Plan:
- Basic conversion: WIDTH=16, DIGITS=4, binary_in=1234 accepted at E0 → done pulses in the cycle after E17. bcd_out=16'h1234. seg digits 3..0 = 1111001, 0100100, 0110000, 0011001. overflow=0.
- Boundary at maximum: 9999 → bcd_out=16'h9999, overflow=0. Then 10000 → overflow=1, all four seg digits=0111111.
- Maximum input: 65535 → overflow=1, all dashes, bcd_out=16'h5535.
- Zero input: 0 with SEG_LZ_BLANK_EN defined → seg0=1000000, seg1..3=1111111. Without the macro → all four digits show 1000000.
- Back-to-back: 42 then 7, with in_valid held high → second accept occurs in the done cycle of the first. Second done follows 18 cycles later, with bcd_out=16'h0007. in_ready=0 throughout each SHIFT/LATCH.
- Reset mid-conversion: rst=0 at edge E5 of a 500 conversion → seg all 1s, bcd_out=0, done never pulses for 500, in_ready=1 after reset. A following 321 converts correctly.
